// File: rtl/hmc_rf_arbiter.sv
// hmc_rf_arbiter: round-robin sharing of one openHMC register-file port among NUM_REQ requesters.
// Define HMC_RF_ARB_TIMEOUT_EN to build the WAIT watchdog (2^TIMEOUT_LOG cycles).
module hmc_rf_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int HMC_RF_AWIDTH = 4,
    parameter int HMC_RF_WWIDTH = 64,
    parameter int HMC_RF_RWIDTH = 64,
    parameter int TIMEOUT_LOG   = 8
) (
    input  logic                               clk_hmc,
    input  logic                               res_hmc,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*HMC_RF_AWIDTH-1:0]   req_address,
    input  logic [NUM_REQ*HMC_RF_WWIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [NUM_REQ-1:0]                 done,
    output logic [HMC_RF_RWIDTH-1:0]           rsp_rdata,
    output logic                               rsp_invalid,
    output logic                               rsp_timeout,
    output logic [HMC_RF_AWIDTH-1:0]           rf_address,
    output logic [HMC_RF_WWIDTH-1:0]           rf_write_data,
    output logic                               rf_read_en,
    output logic                               rf_write_en,
    input  logic [HMC_RF_RWIDTH-1:0]           rf_read_data,
    input  logic                               rf_access_complete,
    input  logic                               rf_invalid_address
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state_q;
    logic [PW-1:0] ptr_q, win_q, win_d, off;
    logic [NUM_REQ-1:0] rot, grant_q, done_q;
    logic [PW:0] sum;
    logic rd_en_q, wr_en_q, wr_q, inv_q;
    logic [HMC_RF_AWIDTH-1:0] addr_q;
    logic [HMC_RF_WWIDTH-1:0] wdata_q;
    logic [HMC_RF_RWIDTH-1:0] rdata_q;
    logic [HMC_RF_AWIDTH-1:0] addr_a [NUM_REQ];
    logic [HMC_RF_WWIDTH-1:0] wdata_a [NUM_REQ];
`ifdef HMC_RF_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_LOG-1:0] LIM = TIMEOUT_LOG'((1 << TIMEOUT_LOG) - 2);
    logic [TIMEOUT_LOG-1:0] cnt_q;
    logic to_q;
`endif
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign addr_a[g]  = req_address[g*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
            assign wdata_a[g] = req_wdata[g*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
        end
    endgenerate
    // Rotate so ptr sits at bit 0; the lowest set bit is the offset of the winner.
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr_q);
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) off = rot[k] ? PW'(k) : off;
        sum = {1'b0, ptr_q} + {1'b0, off};
        win_d = sum >= NR ? PW'(sum - NR) : sum[PW-1:0];
    end
    always_ff @(posedge clk_hmc or posedge res_hmc) begin
        if (res_hmc) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            inv_q   <= 1'b0;
`ifdef HMC_RF_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: if (|req) begin
                    state_q <= ISSUE;
                    win_q   <= win_d;
                    ptr_q   <= win_d == LAST ? '0 : win_d + PW'(1);
                    wr_q    <= req_write[win_d];
                    addr_q  <= addr_a[win_d];
                    wdata_q <= wdata_a[win_d];
                    grant_q <= ONE << win_d;
                    wr_en_q <= req_write[win_d];
                    rd_en_q <= !req_write[win_d];
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef HMC_RF_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
`ifdef HMC_RF_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + TIMEOUT_LOG'(1);
`endif
                    if (rf_access_complete) begin
                        state_q <= IDLE;
                        done_q  <= ONE << win_q;
                        rdata_q <= wr_q ? '0 : rf_read_data;
                        inv_q   <= rf_invalid_address;
`ifdef HMC_RF_ARB_TIMEOUT_EN
                        to_q    <= 1'b0;
                    end else if (cnt_q == LIM) begin
                        state_q <= IDLE;
                        done_q  <= ONE << win_q;
                        rdata_q <= '0;
                        inv_q   <= 1'b0;
                        to_q    <= 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign grant         = grant_q;
    assign done          = done_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_invalid   = inv_q;
    assign rf_address    = addr_q;
    assign rf_write_data = wdata_q;
    assign rf_read_en    = rd_en_q;
    assign rf_write_en   = wr_en_q;
`ifdef HMC_RF_ARB_TIMEOUT_EN
    assign rsp_timeout   = to_q;
`else
    // Constant 0; the comparison only keeps TIMEOUT_LOG referenced without the watchdog.
    assign rsp_timeout   = TIMEOUT_LOG < 0;
`endif
endmodule

// File: tb/tb_hmc_rf_arbiter.sv
// tb_hmc_rf_arbiter: directed test-plan scenarios plus randomized traffic, checked every cycle
// against an access-level reference model (arbitration by modulo search, timing by access age).
module tb_hmc_rf_arbiter;
    localparam int N = 3, AW = 4, WW = 64, RW = 64, TL = 4;
`ifdef HMC_RF_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk_hmc = 1'b0, res_hmc;
    logic [N-1:0] req, req_write, grant, done;
    logic [N*AW-1:0] req_address;
    logic [N*WW-1:0] req_wdata;
    logic [RW-1:0] rsp_rdata, rf_read_data;
    logic rsp_invalid, rsp_timeout, rf_read_en, rf_write_en, rf_access_complete, rf_invalid_address;
    logic [AW-1:0] rf_address;
    logic [WW-1:0] rf_write_data;

    hmc_rf_arbiter #(.NUM_REQ(N), .HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW),
                     .HMC_RF_RWIDTH(RW), .TIMEOUT_LOG(TL)) dut (
        .clk_hmc(clk_hmc), .res_hmc(res_hmc), .req(req), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata), .grant(grant), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
        .rf_address(rf_address), .rf_write_data(rf_write_data), .rf_read_en(rf_read_en),
        .rf_write_en(rf_write_en), .rf_read_data(rf_read_data),
        .rf_access_complete(rf_access_complete), .rf_invalid_address(rf_invalid_address));

    always #5 clk_hmc = ~clk_hmc;

    int n_chk = 0, n_pass = 0;
    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: one access at a time, described by its owner and age in cycles since grant.
    int m_ptr = 0, m_age = 0, m_own = 0;
    bit m_busy = 0, m_wr = 0;
    logic [N-1:0] e_grant, e_done;
    logic e_rd, e_wr, e_inv, e_to;
    logic [AW-1:0] e_addr;
    logic [WW-1:0] e_wdata;
    logic [RW-1:0] e_rdata;
    logic s_res, s_cmp, s_inv;
    logic [N-1:0] s_req, s_wr;
    logic [N*AW-1:0] s_addr;
    logic [N*WW-1:0] s_wdata;
    logic [RW-1:0] s_rdata;

    task model_step();
        int w;
        bit found;
        e_grant = '0; e_done = '0; e_rd = 1'b0; e_wr = 1'b0;
        if (s_res) begin
            m_ptr = 0; m_busy = 0; m_age = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_inv = 1'b0; e_to = 1'b0;
        end else if (!m_busy) begin
            found = 0; w = 0;
            for (int o = 0; o < N; o++)
                if (!found && s_req[(m_ptr + o) % N]) begin found = 1; w = (m_ptr + o) % N; end
            if (found) begin
                m_busy = 1; m_age = 0; m_own = w; m_wr = s_wr[w];
                e_addr = s_addr[w*AW +: AW];
                e_wdata = s_wdata[w*WW +: WW];
                e_grant[w] = 1'b1; e_wr = m_wr; e_rd = !m_wr;
                m_ptr = (w + 1) % N;
            end
        end else begin
            m_age++;
            if (m_age >= 2 && s_cmp) begin
                e_done[m_own] = 1'b1; e_rdata = m_wr ? '0 : s_rdata; e_inv = s_inv; e_to = 1'b0; m_busy = 0;
            end else if (TO_EN && m_age == (1 << TL)) begin
                e_done[m_own] = 1'b1; e_rdata = '0; e_inv = 1'b0; e_to = 1'b1; m_busy = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk_hmc);
        s_res = res_hmc; s_req = req; s_wr = req_write; s_addr = req_address; s_wdata = req_wdata;
        s_cmp = rf_access_complete; s_inv = rf_invalid_address; s_rdata = rf_read_data;
        #1;
        model_step();
        chk("grant", grant, e_grant);
        chk("done", done, e_done);
        chk("rd_en", rf_read_en, e_rd);
        chk("wr_en", rf_write_en, e_wr);
        chk("rw_excl", rf_read_en & rf_write_en, 0);
        chk("rf_address", rf_address, e_addr);
        chk("rf_write_data", rf_write_data, e_wdata);
        if (e_done != '0 || s_res) begin
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_invalid", rsp_invalid, e_inv);
            chk("rsp_timeout", rsp_timeout, e_to);
        end
    end

    task automatic tick();
        @(negedge clk_hmc);
    endtask

    initial begin
        logic [N-1:0] order [$];
        int lat = 0;
        res_hmc = 1'b1; req = '0; req_write = '0; req_address = '0; req_wdata = '0;
        rf_access_complete = 1'b0; rf_read_data = '0; rf_invalid_address = 1'b0;
        repeat (3) tick();
        chk("reset_grant", grant, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        res_hmc = 1'b0;
        tick();
        // Single read: req in cycle 0, grant cycle 1, complete cycle 4, done cycle 5
        req = 3'b001; req_write = '0; req_address[3:0] = 4'h3;
        tick();
        chk("sr_grant", grant, 3'b001);
        chk("sr_rd_en", rf_read_en, 1);
        chk("sr_wr_en", rf_write_en, 0);
        chk("sr_addr", rf_address, 4'h3);
        req = '0;
        repeat (3) tick();
        chk("sr_done_early", done, 0);
        rf_access_complete = 1'b1; rf_read_data = 64'hDEAD_BEEF;
        tick();
        chk("sr_done", done, 3'b001);
        chk("sr_rdata", rsp_rdata, 64'hDEAD_BEEF);
        rf_access_complete = 1'b0;
        tick();
        // Reset mid-access: outputs clear at once, late complete ignored, pointer back to 0
        req = 3'b001;
        tick();
        chk("rm_grant", grant, 3'b001);
        req = '0;
        repeat (2) tick();
        res_hmc = 1'b1;
        #1;
        chk("rm_zero_rdata", rsp_rdata, 0);
        chk("rm_zero_addr", rf_address, 0);
        chk("rm_zero_en", {rf_read_en, rf_write_en, grant, done}, 0);
        tick();
        res_hmc = 1'b0; rf_access_complete = 1'b1;
        tick();
        rf_access_complete = 1'b0;
        chk("rm_no_done", done, 0);
        // Contention: req0 and req1 held, complete held; strict alternation starting at 0
        req = 3'b011; rf_access_complete = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (grant != '0) order.push_back(grant);
            if (c == 10) req = '0;
        end
        chk("ct_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("ct_order", order[i], (i % 2 == 0) ? 3'b001 : 3'b010);
        rf_access_complete = 1'b0;
        repeat (2) tick();
        // Invalid address on a write from requester 1
        req = 3'b010; req_write = 3'b010; req_address[7:4] = 4'hF; req_wdata[127:64] = 64'hCAFE_F00D;
        tick();
        chk("ia_grant", grant, 3'b010);
        chk("ia_wr_en", rf_write_en, 1);
        chk("ia_wdata", rf_write_data, 64'hCAFE_F00D);
        req = '0;
        tick();
        rf_access_complete = 1'b1; rf_invalid_address = 1'b1; rf_read_data = 64'h1234_5678;
        tick();
        chk("ia_done", done, 3'b010);
        chk("ia_invalid", rsp_invalid, 1);
        chk("ia_rdata", rsp_rdata, 0);
        rf_access_complete = 1'b0; rf_invalid_address = 1'b0; req_write = '0;
        tick();
        // Back-to-back: next grant one cycle after done
        req = 3'b001;
        tick();
        chk("bb_grant1", grant, 3'b001);
        tick();
        rf_access_complete = 1'b1;
        tick();
        chk("bb_done", done, 3'b001);
        rf_access_complete = 1'b0;
        tick();
        chk("bb_grant2", grant, 3'b001);
        req = '0;
        tick();
        rf_access_complete = 1'b1;
        tick();
        chk("bb_done2", done, 3'b001);
        rf_access_complete = 1'b0;
        tick();
`ifdef HMC_RF_ARB_TIMEOUT_EN
        // Watchdog: grant cycle 1, no complete, done cycle 17 with timeout
        req = 3'b001;
        tick();
        chk("wd_grant", grant, 3'b001);
        req = '0;
        repeat (15) tick();
        chk("wd_early", done, 0);
        tick();
        chk("wd_done", done, 3'b001);
        chk("wd_timeout", rsp_timeout, 1);
        rf_access_complete = 1'b1;
        tick();
        rf_access_complete = 1'b0;
        chk("wd_late", done, 0);
`endif
        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i] = $urandom_range(3, 0) != 0;
                req_write[i] = 1'($urandom);
                req_address[i*AW +: AW] = AW'($urandom);
                req_wdata[i*WW +: WW] = {$urandom, $urandom};
            end
            rf_read_data = {$urandom, $urandom};
            rf_invalid_address = $urandom_range(3, 0) == 0;
            if (m_busy && m_age == 0)
                lat = (TO_EN && $urandom_range(5, 0) == 0) ? 1000 : int'($urandom_range(4, 0));
            if (m_busy && m_age >= 1) begin
                rf_access_complete = lat == 0;
                lat--;
            end else rf_access_complete = $urandom_range(2, 0) == 0;
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
